video_stream_frame_arbiter: RTL and testbench

- Shares the single AXI4-Stream video sink (32-bit tdata, tuser = start of frame, tlast = end of line) between two video sources.
- Typical sources are the test-pattern generator and the framebuffer reader.
- Switches sources only on frame boundaries, so the downstream video output never sees a torn frame.
- Tracks line and pixel position against configured geometry, flags framing errors, and resynchronises on them.

---
 rtl/video_pkg.sv | 24 ++
 rtl/video_frame_tracker.sv | 101 ++++++++++
 rtl/video_stream_frame_arbiter.sv | 174 +++++++++++++++++
 tb/tb_video_stream_frame_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and default widths for the video stream frame arbiter.
//   VID_DATA_W / VID_CNT_W / VID_FCNT_W : default tdata, geometry and frame counter widths
//   vid_state_e                         : arbiter FSM state
//   vid_beat_t                          : one AXI4-Stream video beat (tdata, tuser = SOF, tlast = EOL, tvalid)
package video_pkg;

    localparam int unsigned VID_DATA_W = 32;
    localparam int unsigned VID_CNT_W  = 12;
    localparam int unsigned VID_FCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        PASS = 2'd2
    } vid_state_e;

    typedef struct packed {
        logic [VID_DATA_W-1:0] tdata;
        logic                  tuser;
        logic                  tlast;
        logic                  tvalid;
    } vid_beat_t;

endpackage

// File: rtl/video_frame_tracker.sv
// Pixel/line position tracker for the forwarded stream.
// Latches frame geometry, counts handshakes, detects end of frame and
// flags start-of-frame and end-of-line framing errors.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_load_geom         : capture i_h_pixels / i_v_lines (HUNT entry)
//   i_h_pixels/v_lines  : configured geometry (both >= 1)
//   i_clear             : zero the pixel/line counters (HUNT -> PASS)
//   i_hs                : handshake on the owned stream
//   i_tuser, i_tlast    : sideband of the owned stream beat
//   o_eof_c             : combinational end-of-frame (final tlast handshake)
//   o_err_sof/o_err_eol : one-cycle registered error pulses
module video_frame_tracker
    import video_pkg::*;
#(
    parameter int unsigned CNT_W = VID_CNT_W
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_geom,
    input  logic [CNT_W-1:0] i_h_pixels,
    input  logic [CNT_W-1:0] i_v_lines,
    input  logic             i_clear,
    input  logic             i_hs,
    input  logic             i_tuser,
    input  logic             i_tlast,
    output logic             o_eof_c,
    output logic             o_err_sof,
    output logic             o_err_eol
);

    logic [CNT_W-1:0] r_h_pixels;
    logic [CNT_W-1:0] r_v_lines;
    logic [CNT_W-1:0] r_pix;
    logic [CNT_W-1:0] r_line;
    logic             r_err_sof;
    logic             r_err_eol;

    logic [CNT_W-1:0] w_pix_e;
    logic [CNT_W-1:0] w_line_e;
    logic             w_last_pix;
    logic             w_last_line;
    logic             w_sof_err;
    logic             w_eol_err;

    // A tuser beat always counts as pix 0 of line 0, so a mid-frame SOF resyncs here.
    always_comb begin
        w_pix_e     = i_tuser ? '0 : r_pix;
        w_line_e    = i_tuser ? '0 : r_line;
        w_last_pix  = (w_pix_e  == CNT_W'(r_h_pixels - CNT_W'(1)));
        w_last_line = (w_line_e == CNT_W'(r_v_lines  - CNT_W'(1)));
        w_sof_err   = i_hs & i_tuser & ((r_pix != '0) | (r_line != '0));
        // Early tlast, or a non-tlast beat on the last pixel position (overlong line).
        w_eol_err   = i_hs & (i_tlast ? ~w_last_pix : w_last_pix);
        o_eof_c     = i_hs & i_tlast & w_last_line;
    end

    // Geometry latch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_pixels <= '0;
            r_v_lines  <= '0;
        end else if (i_load_geom) begin
            r_h_pixels <= i_h_pixels;
            r_v_lines  <= i_v_lines;
        end
    end

    // Position counters; pix saturates at the last position until tlast arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pix  <= '0;
            r_line <= '0;
        end else if (i_clear) begin
            r_pix  <= '0;
            r_line <= '0;
        end else if (i_hs) begin
            if (i_tlast) begin
                r_pix  <= '0;
                r_line <= w_last_line ? '0 : CNT_W'(w_line_e + CNT_W'(1));
            end else begin
                r_pix  <= w_last_pix ? w_pix_e : CNT_W'(w_pix_e + CNT_W'(1));
                r_line <= w_line_e;
            end
        end
    end

    // Error pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_sof <= 1'b0;
            r_err_eol <= 1'b0;
        end else begin
            r_err_sof <= w_sof_err;
            r_err_eol <= w_eol_err;
        end
    end

    assign o_err_sof = r_err_sof;
    assign o_err_eol = r_err_eol;

endmodule

// File: rtl/video_stream_frame_arbiter.sv
// Two-source AXI4-Stream video arbiter that changes owner only on frame boundaries.
//   aclk, areset          : clock, asynchronous active-high reset
//   cfg_enable, cfg_sel   : forward enable, requested source
//   cfg_h_pixels/v_lines  : frame geometry, latched on HUNT entry
//   s0_axis_vid_*         : source 0 stream (tready out)
//   s1_axis_vid_*         : source 1 stream (tready out)
//   m_axis_vid_*          : output stream, combinationally forwarded in PASS
//   stat_cur_sel/active   : owned source, PASS indicator
//   stat_frame_cnt        : completed forwarded frames (wraps)
//   err_sof, err_eol      : framing error pulses
module video_stream_frame_arbiter
    import video_pkg::*;
#(
    parameter int unsigned DATA_W = VID_DATA_W,
    parameter int unsigned CNT_W  = VID_CNT_W,
    parameter int unsigned FCNT_W = VID_FCNT_W
)(
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_enable,
    input  logic              cfg_sel,
    input  logic [CNT_W-1:0]  cfg_h_pixels,
    input  logic [CNT_W-1:0]  cfg_v_lines,
    input  logic [DATA_W-1:0] s0_axis_vid_tdata,
    input  logic              s0_axis_vid_tuser,
    input  logic              s0_axis_vid_tlast,
    input  logic              s0_axis_vid_tvalid,
    output logic              s0_axis_vid_tready,
    input  logic [DATA_W-1:0] s1_axis_vid_tdata,
    input  logic              s1_axis_vid_tuser,
    input  logic              s1_axis_vid_tlast,
    input  logic              s1_axis_vid_tvalid,
    output logic              s1_axis_vid_tready,
    output logic [DATA_W-1:0] m_axis_vid_tdata,
    output logic              m_axis_vid_tuser,
    output logic              m_axis_vid_tlast,
    output logic              m_axis_vid_tvalid,
    input  logic              m_axis_vid_tready,
    output logic              stat_cur_sel,
    output logic              stat_active,
    output logic [FCNT_W-1:0] stat_frame_cnt,
    output logic              err_sof,
    output logic              err_eol
);

    vid_state_e        r_state;
    vid_state_e        w_next;
    logic              r_cur_sel;
    logic [FCNT_W-1:0] r_frame_cnt;

    vid_beat_t w_s0;
    vid_beat_t w_s1;
    vid_beat_t w_own;
    vid_beat_t w_m;
    logic      w_own_tready;
    logic      w_hs;
    logic      w_eof;
    logic      w_load_geom;
    logic      w_clear;

    // Pack sources into beats; tdata is resized to the package beat width.
    always_comb begin
        w_s0.tdata  = VID_DATA_W'(s0_axis_vid_tdata);
        w_s0.tuser  = s0_axis_vid_tuser;
        w_s0.tlast  = s0_axis_vid_tlast;
        w_s0.tvalid = s0_axis_vid_tvalid;
        w_s1.tdata  = VID_DATA_W'(s1_axis_vid_tdata);
        w_s1.tuser  = s1_axis_vid_tuser;
        w_s1.tlast  = s1_axis_vid_tlast;
        w_s1.tvalid = s1_axis_vid_tvalid;
        w_own       = r_cur_sel ? w_s1 : w_s0;
    end

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; PASS leaves only on the final handshake of a frame.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cfg_enable) begin
                    w_next = HUNT;
                end
            end
            HUNT: begin
                if (!cfg_enable) begin
                    w_next = IDLE;
                end else if (w_own.tvalid && w_own.tuser) begin
                    w_next = PASS;
                end
            end
            PASS: begin
                if (w_eof) begin
                    if (!cfg_enable) begin
                        w_next = IDLE;
                    end else if (cfg_sel != r_cur_sel) begin
                        w_next = HUNT;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Output / control logic; the SOF beat seen in HUNT is held back for PASS.
    always_comb begin
        w_m          = '0;
        w_own_tready = 1'b1;
        case (r_state)
            HUNT:    w_own_tready = ~(w_own.tvalid & w_own.tuser);
            PASS: begin
                w_m          = w_own;
                w_own_tready = m_axis_vid_tready;
            end
            default: ;
        endcase
        w_hs        = (r_state == PASS) & w_own.tvalid & m_axis_vid_tready;
        w_load_geom = (w_next == HUNT) && (r_state != HUNT);
        w_clear     = (r_state == HUNT) && (w_next == PASS);
    end

    // Owner capture and frame counter
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cur_sel   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_load_geom) begin
                r_cur_sel <= cfg_sel;
            end
            if (w_eof) begin
                r_frame_cnt <= FCNT_W'(r_frame_cnt + FCNT_W'(1));
            end
        end
    end

    video_frame_tracker #(
        .CNT_W (CNT_W)
    ) u_tracker (
        .i_clk       (aclk),
        .i_rst       (areset),
        .i_load_geom (w_load_geom),
        .i_h_pixels  (cfg_h_pixels),
        .i_v_lines   (cfg_v_lines),
        .i_clear     (w_clear),
        .i_hs        (w_hs),
        .i_tuser     (w_own.tuser),
        .i_tlast     (w_own.tlast),
        .o_eof_c     (w_eof),
        .o_err_sof   (err_sof),
        .o_err_eol   (err_eol)
    );

    // Non-owned source is always drained.
    assign s0_axis_vid_tready = r_cur_sel ? 1'b1 : w_own_tready;
    assign s1_axis_vid_tready = r_cur_sel ? w_own_tready : 1'b1;

    assign m_axis_vid_tdata  = DATA_W'(w_m.tdata);
    assign m_axis_vid_tuser  = w_m.tuser;
    assign m_axis_vid_tlast  = w_m.tlast;
    assign m_axis_vid_tvalid = w_m.tvalid;

    assign stat_cur_sel   = r_cur_sel;
    assign stat_active    = (r_state == PASS);
    assign stat_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_stream_frame_arbiter.sv
// Directed bench for video_stream_frame_arbiter (geometry 4x3, 12 beats per frame).
module tb_video_stream_frame_arbiter;

    logic        aclk;
    logic        areset;
    logic        cfg_enable;
    logic        cfg_sel;
    logic [11:0] cfg_h_pixels;
    logic [11:0] cfg_v_lines;
    logic [31:0] s0_tdata;
    logic        s0_tuser, s0_tlast, s0_tvalid, s0_tready;
    logic [31:0] s1_tdata;
    logic        s1_tuser, s1_tlast, s1_tvalid, s1_tready;
    logic [31:0] m_tdata;
    logic        m_tuser, m_tlast, m_tvalid, m_tready;
    logic        stat_cur_sel, stat_active;
    logic [15:0] stat_frame_cnt;
    logic        err_sof, err_eol;

    int n_checks = 0;
    int n_errors = 0;
    int n_sof_pulses = 0;
    int n_eol_pulses = 0;

    video_stream_frame_arbiter dut (
        .aclk               (aclk),
        .areset             (areset),
        .cfg_enable         (cfg_enable),
        .cfg_sel            (cfg_sel),
        .cfg_h_pixels       (cfg_h_pixels),
        .cfg_v_lines        (cfg_v_lines),
        .s0_axis_vid_tdata  (s0_tdata),
        .s0_axis_vid_tuser  (s0_tuser),
        .s0_axis_vid_tlast  (s0_tlast),
        .s0_axis_vid_tvalid (s0_tvalid),
        .s0_axis_vid_tready (s0_tready),
        .s1_axis_vid_tdata  (s1_tdata),
        .s1_axis_vid_tuser  (s1_tuser),
        .s1_axis_vid_tlast  (s1_tlast),
        .s1_axis_vid_tvalid (s1_tvalid),
        .s1_axis_vid_tready (s1_tready),
        .m_axis_vid_tdata   (m_tdata),
        .m_axis_vid_tuser   (m_tuser),
        .m_axis_vid_tlast   (m_tlast),
        .m_axis_vid_tvalid  (m_tvalid),
        .m_axis_vid_tready  (m_tready),
        .stat_cur_sel       (stat_cur_sel),
        .stat_active        (stat_active),
        .stat_frame_cnt     (stat_frame_cnt),
        .err_sof            (err_sof),
        .err_eol            (err_eol)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (err_sof) n_sof_pulses <= n_sof_pulses + 1;
        if (err_eol) n_eol_pulses <= n_eol_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit src, input logic [31:0] d, input bit u, input bit l, input bit v);
        if (src) begin
            s1_tdata = d; s1_tuser = u; s1_tlast = l; s1_tvalid = v;
        end else begin
            s0_tdata = d; s0_tuser = u; s0_tlast = l; s0_tvalid = v;
        end
    endtask

    // Offer one beat until accepted. fwd=1: must appear on m_* at the handshake.
    // fwd=0: must be drained at once with m_tvalid low. rnd: random m_tready.
    task automatic beat(input bit src, input logic [31:0] d, input bit u, input bit l,
                        input bit fwd, input bit rnd);
        bit   done;
        int   n;
        logic rdy;
        done = 1'b0;
        n    = 0;
        drive(src, d, u, l, 1'b1);
        while (!done) begin
            if (rnd) m_tready = 1'($urandom_range(0, 1));
            #1;
            rdy = src ? s1_tready : s0_tready;
            if (fwd) begin
                if (rnd && stat_active) chk("tready_follow", 32'(rdy), 32'(m_tready));
                if (rdy) begin
                    chk("m_tvalid", 32'(m_tvalid), 32'd1);
                    chk("m_tdata",  m_tdata, d);
                    chk("m_tuser",  32'(m_tuser), 32'(u));
                    chk("m_tlast",  32'(m_tlast), 32'(l));
                    done = 1'b1;
                end
            end else begin
                chk("drain_tready", 32'(rdy), 32'd1);
                chk("drain_quiet",  32'(m_tvalid), 32'd0);
                done = 1'b1;
            end
            @(posedge aclk);
            #1;
            n++;
            if (!done && n > 60) begin
                chk("beat_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        drive(src, 32'd0, 1'b0, 1'b0, 1'b0);
        if (rnd) m_tready = 1'b1;
    endtask

    // Beats first..last of a 4x3 stream: tuser at index%12==0, tlast at index%4==3.
    task automatic beats(input bit src, input logic [31:0] base, input int first, input int last,
                         input bit fwd, input bit rnd);
        for (int i = first; i <= last; i++) begin
            beat(src, base + 32'(i), (i % 12) == 0, (i % 4) == 3, fwd, rnd);
        end
    endtask

    initial begin
        areset = 1'b1; cfg_enable = 1'b0; cfg_sel = 1'b0;
        cfg_h_pixels = 12'd4; cfg_v_lines = 12'd3; m_tready = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata",  m_tdata, 32'd0);
        chk("rst_active",   32'(stat_active), 32'd0);
        chk("rst_frame_cnt", 32'(stat_frame_cnt), 32'd0);
        chk("rst_cur_sel",  32'(stat_cur_sel), 32'd0);
        chk("rst_s0_tready", 32'(s0_tready), 32'd1);
        chk("rst_s1_tready", 32'(s1_tready), 32'd1);
        chk("rst_errs",     32'({err_sof, err_eol}), 32'd0);

        // Two clean frames from s0
        @(posedge aclk); #1;
        cfg_enable = 1'b1;
        @(posedge aclk); #1;
        chk("hunt_active", 32'(stat_active), 32'd0);
        beats(1'b0, 32'h1000, 0, 23, 1'b1, 1'b0);
        chk("t1_frame_cnt", 32'(stat_frame_cnt), 32'd2);
        chk("t1_active", 32'(stat_active), 32'd1);
        chk("t1_sof_pulses", 32'(n_sof_pulses), 32'd0);
        chk("t1_eol_pulses", 32'(n_eol_pulses), 32'd0);

        // One frame with random sink backpressure
        beats(1'b0, 32'h3000, 0, 11, 1'b1, 1'b1);
        chk("t4_frame_cnt", 32'(stat_frame_cnt), 32'd3);

        // Reset in the middle of PASS
        beats(1'b0, 32'h4000, 0, 1, 1'b1, 1'b0);
        drive(1'b0, 32'h4002, 1'b0, 1'b0, 1'b1);
        areset = 1'b1;
        #1;
        chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("arst_active",   32'(stat_active), 32'd0);
        chk("arst_frame_cnt", 32'(stat_frame_cnt), 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Source joins mid-frame: line 1 and line 2 drained, then a full frame
        beats(1'b0, 32'h5000, 4, 11, 1'b0, 1'b0);
        beats(1'b0, 32'h5100, 0, 11, 1'b1, 1'b0);
        chk("t2_frame_cnt", 32'(stat_frame_cnt), 32'd1);

        // Source switch requested during line 1 takes effect at frame end
        beats(1'b0, 32'h6000, 0, 3, 1'b1, 1'b0);
        cfg_sel = 1'b1;
        beats(1'b0, 32'h6000, 4, 10, 1'b1, 1'b0);
        chk("t3_sel_held", 32'(stat_cur_sel), 32'd0);
        beats(1'b0, 32'h6000, 11, 11, 1'b1, 1'b0);
        chk("t3_sel_new",   32'(stat_cur_sel), 32'd1);
        chk("t3_hunting",   32'(stat_active), 32'd0);
        chk("t3_frame_cnt", 32'(stat_frame_cnt), 32'd2);
        chk("t3_s0_drain",  32'(s0_tready), 32'd1);
        beats(1'b1, 32'h7000, 0, 11, 1'b1, 1'b0);
        chk("t3_s1_frame_cnt", 32'(stat_frame_cnt), 32'd3);

        // Short line (3 pixels with tlast) ending a counted frame
        beats(1'b1, 32'h8000, 0, 3, 1'b1, 1'b0);
        beat(1'b1, 32'h8004, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(1'b1, 32'h8005, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(1'b1, 32'h8006, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_err_eol", 32'(err_eol), 32'd1);
        beats(1'b1, 32'h8100, 8, 11, 1'b1, 1'b0);
        chk("t5_eol_once", 32'(n_eol_pulses), 32'd1);
        chk("t5_frame_cnt", 32'(stat_frame_cnt), 32'd4);

        // Stray tuser at pix 2 of line 1 restarts the frame
        beats(1'b1, 32'h9000, 0, 5, 1'b1, 1'b0);
        beat(1'b1, 32'h9100, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_err_sof",   32'(err_sof), 32'd1);
        chk("t5_no_eol",    32'(err_eol), 32'd0);
        chk("t5_broken_cnt", 32'(stat_frame_cnt), 32'd4);
        beats(1'b1, 32'h9100, 1, 10, 1'b1, 1'b0);
        chk("t5_not_yet",   32'(stat_frame_cnt), 32'd4);
        beats(1'b1, 32'h9100, 11, 11, 1'b1, 1'b0);
        chk("t5_resync_cnt", 32'(stat_frame_cnt), 32'd5);

        // Disable mid-frame: frame completes, then IDLE drains
        beats(1'b1, 32'hA000, 0, 5, 1'b1, 1'b0);
        cfg_enable = 1'b0;
        beats(1'b1, 32'hA000, 6, 11, 1'b1, 1'b0);
        chk("t6_idle",      32'(stat_active), 32'd0);
        chk("t6_frame_cnt", 32'(stat_frame_cnt), 32'd6);
        beat(1'b1, 32'hB000, 1'b1, 1'b0, 1'b0, 1'b0);

        @(posedge aclk); #1;
        chk("end_sof_pulses", 32'(n_sof_pulses), 32'd1);
        chk("end_eol_pulses", 32'(n_eol_pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
